// File: rtl/lut_k_srl_frame_config_dffesr.sv
// K-input LUT logic element with configurable FF, iCE40-style carry and SRL mode.
// Optional macro LUT_SRL_CASCADE_EN adds the SRLo cascade output (srl[N-1]).
module lut_k_srl_frame_config_dffesr #(
  parameter int LUT_SIZE     = 4,
  parameter int NoConfigBits = 20
) (
  input  logic                    UserCLK,
  input  logic                    SR,
  input  logic                    EN,
  input  logic [LUT_SIZE-1:0]     I,
  input  logic                    Ci,
  input  logic                    D,
  output logic                    O,
  output logic                    Co,
`ifdef LUT_SRL_CASCADE_EN
  output logic                    SRLo,
`endif
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int N = 2 ** LUT_SIZE;

  if (LUT_SIZE < 3 || LUT_SIZE > 6 || NoConfigBits != N + 4) begin : g_bad_params
    $error("lut_k_srl_frame_config_dffesr: illegal LUT_SIZE/NoConfigBits");
  end

  function automatic logic cus_mux21(input logic a0, input logic a1, input logic s);
    return s ? a1 : a0;
  endfunction

  logic [N-1:0]        init_s;
  logic                ff_sel_s;
  logic                iomux_s;
  logic                set_noreset_s;
  logic                srl_mode_s;
  logic                i0mux_s;
  logic [LUT_SIZE-1:0] lut_index_s;
  logic                lut_out_s;
  logic [N-1:0]        srl_q;
  logic [N-1:0]        srl_d;
  logic                ff_q;
  logic                ff_d;

  assign init_s        = ConfigBits[N-1:0];
  assign ff_sel_s      = ConfigBits[N];
  assign iomux_s       = ConfigBits[N+1];
  assign set_noreset_s = ConfigBits[N+2];
  assign srl_mode_s    = ConfigBits[N+3];

  assign i0mux_s     = cus_mux21(I[0], Ci, iomux_s);
  assign lut_index_s = {I[LUT_SIZE-1:1], i0mux_s};

  // LUT read: truth table in LUT mode, live shift register in SRL mode.
  always_comb begin
    lut_out_s = 1'b0;
    if (srl_mode_s) begin
      lut_out_s = srl_q[lut_index_s];
    end else begin
      lut_out_s = init_s[lut_index_s];
    end
  end

  // Next-state for the shift register and the FF; FF samples the pre-shift read.
  always_comb begin
    srl_d = srl_q;
    ff_d  = ff_q;
    if (EN) begin
      ff_d = lut_out_s;
      if (srl_mode_s) begin
        srl_d = {srl_q[N-2:0], D};
      end else begin
        srl_d = srl_q;
      end
    end else begin
      srl_d = srl_q;
      ff_d  = ff_q;
    end
  end

  // Shift register: SR reloads the truth table asynchronously.
  always_ff @(posedge UserCLK or posedge SR) begin
    if (SR) begin
      srl_q <= init_s;
    end else begin
      srl_q <= srl_d;
    end
  end

  // Output FF: SR forces the configured set/clear value.
  always_ff @(posedge UserCLK or posedge SR) begin
    if (SR) begin
      ff_q <= set_noreset_s;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign O  = cus_mux21(lut_out_s, ff_q, ff_sel_s);
  assign Co = (Ci & I[1]) | (Ci & I[2]) | (I[1] & I[2]);

`ifdef LUT_SRL_CASCADE_EN
  assign SRLo = srl_q[N-1];
`endif

endmodule

// File: tb/tb_lut_k_srl_frame_config_dffesr.sv
// Self-checking bench: behavioural model of the LUT/SRL/FF element, directed
// literal checks from the test plan, then randomized traffic.
module tb_lut_k_srl_frame_config_dffesr;

  logic        clk = 1'b0;
  logic        sr = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  i_v = 4'd0;
  logic        ci = 1'b0;
  logic        d = 1'b0;
  logic        o;
  logic        co;
  logic [15:0] init_v = 16'h0000;
  logic        ffb = 1'b0;
  logic        iomux = 1'b0;
  logic        setnr = 1'b0;
  logic        mode = 1'b0;
  logic [19:0] cfg;
`ifdef LUT_SRL_CASCADE_EN
  logic        srlo;
`endif

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;

  // model state
  logic [15:0] srl_m = 16'h0000;
  logic        ff_m = 1'b0;

  assign cfg = {mode, setnr, iomux, ffb, init_v};

  lut_k_srl_frame_config_dffesr #(.LUT_SIZE(4), .NoConfigBits(20)) dut (
    .UserCLK(clk), .SR(sr), .EN(en), .I(i_v), .Ci(ci), .D(d),
    .O(o), .Co(co),
`ifdef LUT_SRL_CASCADE_EN
    .SRLo(srlo),
`endif
    .ConfigBits(cfg)
  );

  always #5 clk = ~clk;

  function automatic int idx_f();
    int b0;
    b0 = (iomux ? ci : i_v[0]) ? 1 : 0;
    return int'(i_v[3:1]) * 2 + b0;
  endfunction

  function automatic logic lut_f();
    if (mode) return srl_m[idx_f()];
    return init_v[idx_f()];
  endfunction

  function automatic logic exp_o();
    return ffb ? ff_m : lut_f();
  endfunction

  function automatic logic exp_co();
    return ((int'(ci) + int'(i_v[1]) + int'(i_v[2])) >= 2) ? 1'b1 : 1'b0;
  endfunction

  // reference model: reload on SR, otherwise EN-qualified capture and shift
  always @(posedge clk or posedge sr) begin
    if (sr) begin
      srl_m <= init_v;
      ff_m  <= setnr;
    end else if (en) begin
      ff_m <= lut_f();
      if (mode) srl_m <= {srl_m[14:0], d};
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("O_model", o, exp_o());
      check("Co_model", co, exp_co());
`ifdef LUT_SRL_CASCADE_EN
      check("SRLo_model", srlo, srl_m[15]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_sr();
    sr = 1'b1;
    #1;
    sr = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] maj_tbl;
    logic [2:0] c;
    maj_tbl = 8'b1110_1000;
    init_v = 16'h8000; ffb = 1'b0; mode = 1'b0; iomux = 1'b0; setnr = 1'b0;
    #1 sr = 1'b1;
    #2 chk_on = 1'b1;
    tick();
    sr = 1'b0;

    // LUT mode sweep and carry majority
    for (int k = 0; k < 16; k++) begin
      i_v = 4'(k);
      ci = 1'($urandom_range(0, 1));
      #1 check("lut_sweep", o, (k == 15) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      c = 3'(k);
      ci = c[2]; i_v[2] = c[1]; i_v[1] = c[0];
      #1 check("carry", co, maj_tbl[k]);
    end

    // FF set, capture, hold
    tick();
    ffb = 1'b1; setnr = 1'b1; init_v = 16'h0000;
    sr = 1'b1;
    #1 check("sr_set", o, 1'b1);
    #1 sr = 1'b0; en = 1'b1;
    tick();
    #1 check("ff_capture", o, 1'b0);
    en = 1'b0; init_v = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1 check("ff_hold", o, 1'b0);
    end

    // SRL shift and read latency
    ffb = 1'b0; setnr = 1'b0; mode = 1'b1; init_v = 16'h0000; iomux = 1'b0;
    i_v = 4'd0; ci = 1'b0;
    pulse_sr();
    en = 1'b1; d = 1'b1;
    tick();
    #1 check("srl_edge1", o, 1'b1);
    d = 1'b0; i_v = 4'd3;
    for (int k = 2; k <= 5; k++) begin
      tick();
      #1 check("srl_i3", o, (k == 4) ? 1'b1 : 1'b0);
    end

    // simultaneous capture and shift sees the old value
    ffb = 1'b1; setnr = 1'b0; init_v = 16'h0001; i_v = 4'd0; d = 1'b0;
    pulse_sr();
    tick();
    #1 check("old_capture", o, 1'b1);
    tick();
    #1 check("next_capture", o, 1'b0);

    // async reload after shifting, no shift while SR held
    ffb = 1'b0; init_v = 16'hA5A5; d = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    sr = 1'b1;
    i_v = 4'd0;
    #1 check("reload_i0", o, 1'b1);
    i_v = 4'd1;
    #1 check("reload_i1", o, 1'b0);
    tick();
    #1 check("sr_noshift_i1", o, 1'b0);
    i_v = 4'd0;
    #1 check("sr_noshift_i0", o, 1'b1);
    sr = 1'b0;

`ifdef LUT_SRL_CASCADE_EN
    init_v = 16'h8000; mode = 1'b1;
    pulse_sr();
    #1 check("srlo_reset", srlo, 1'b1);
    d = 1'b0; en = 1'b1;
    tick();
    #1 check("srlo_d0", srlo, 1'b0);
    d = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      #1 check("srlo_fill", srlo, (k == 16) ? 1'b1 : 1'b0);
    end
`endif

    // randomized traffic checked by the model each cycle
    for (int n = 0; n < 600; n++) begin
      tick();
      if (sr) sr = 1'b0;
      i_v = 4'($urandom_range(0, 15));
      ci  = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 24) == 0) begin
        init_v = 16'($urandom_range(0, 65535));
        ffb    = 1'($urandom_range(0, 1));
        iomux  = 1'($urandom_range(0, 1));
        setnr  = 1'($urandom_range(0, 1));
        mode   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      end
      case ($urandom_range(0, 59))
        0: pulse_sr();
        1: sr = 1'b1;
        default: ;
      endcase
    end

    tick();
    sr = 1'b0;
    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
